// File: rtl/y86_pkg.sv
// y86_pkg: definitions shared by the Y86-64 SEQ sequencer, the fetch and
// PC-update logic, and the testbenches.
//   stat_e       processor status encodings (AOK/HLT/ADR/INS)
//   ICODE_*      instruction codes the sequencer reacts to
//   seq_state_e  sequencer stage enum
package y86_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] ICODE_HALT = 4'h0;
  localparam logic [3:0] ICODE_OPQ  = 4'h6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT
  } seq_state_e;

endpackage : y86_pkg

// File: rtl/y86_sat_counter.sv
// y86_sat_counter: W-bit up-counter that sticks at all-ones instead of
// wrapping.
//   clk    clock
//   rst_n  asynchronous active-low reset, clears the count
//   inc    count one when high
//   cnt    current count
module y86_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule : y86_sat_counter

// File: rtl/y86_seq_sequencer.sv
// y86_seq_sequencer: multi-cycle stage controller for the Y86-64 SEQ
// datapath. Walks FETCH, DECODE, EXECUTE, MEMORY (1+MEM_WAIT cycles),
// WRITEBACK and PCUPD one stage per clock, owns the architectural PC and
// status register, and keeps saturating cycle / retired-instruction counts.
//
// Parameters: PC_W, CNT_W, MEM_WAIT (0..15), RESET_PC.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   run                           level, permits starting instructions
//   step (SEQ_STEP_EN only)       single-instruction launch from IDLE
//   icode, imem_err, instr_err    fetch results, sampled at the end of FETCH
//   dmem_err                      sampled on the last MEMORY cycle
//   pc_in                         next PC, loaded at the end of PCUPD
//   fetch_en..pc_en               one-hot stage enables (zero in IDLE/HALT)
//   cc_en                         condition-code enable (EXECUTE of OPq)
//   pc, stat, halted              architectural state
//   cycle_cnt, instr_cnt          saturating counters
//
// Build option: define SEQ_STEP_EN to add the step input.
module y86_seq_sequencer
  import y86_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              CNT_W    = 32,
  parameter int              MEM_WAIT = 0,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
`ifdef SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic [3:0]       icode,
  input  logic             imem_err,
  input  logic             instr_err,
  input  logic             dmem_err,
  input  logic [PC_W-1:0]  pc_in,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             cc_en,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] MEM_WAIT_L = 4'(MEM_WAIT);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  stat_e           stat_q, stat_d;
  logic [3:0]      wait_q, wait_d;
  logic            single_q, single_d;  // current instruction launched by step
  logic            retire;
  logic            start_step;

`ifdef SEQ_STEP_EN
  // run has priority: a step launch only counts when run is low.
  assign start_step = step & ~run;
`else
  assign start_step = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    stat_d   = stat_q;
    wait_d   = wait_q;
    single_d = single_q;
    retire   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run || start_step) begin
          state_d  = S_FETCH;
          single_d = start_step;
        end
      end
      S_FETCH: begin
        if (imem_err) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (instr_err) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == ICODE_HALT) begin
          stat_d  = STAT_HLT;
          retire  = 1'b1;          // halt counts as a retired instruction
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_MEMORY;
        wait_d  = MEM_WAIT_L;      // reload on every entry to MEMORY
      end
      S_MEMORY: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (dmem_err) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d     = pc_in;
        retire   = 1'b1;
        single_d = 1'b0;
        state_d  = (run && !single_q) ? S_FETCH : S_IDLE;
      end
      S_HALT: ;                    // left only through reset
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      stat_q   <= STAT_AOK;
      wait_q   <= 4'd0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      stat_q   <= stat_d;
      wait_q   <= wait_d;
      single_q <= single_d;
    end
  end

  // Moore enables: decoded from the state register only, so reset drops
  // them as soon as it asserts.
  assign fetch_en  = (state_q == S_FETCH);
  assign decode_en = (state_q == S_DECODE);
  assign exec_en   = (state_q == S_EXECUTE);
  assign mem_en    = (state_q == S_MEMORY);
  assign wb_en     = (state_q == S_WRITEBACK);
  assign pc_en     = (state_q == S_PCUPD);
  assign cc_en     = exec_en && (icode == ICODE_OPQ);
  assign halted    = (state_q == S_HALT);
  assign pc        = pc_q;
  assign stat      = stat_q;

  y86_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_q != S_IDLE) && (state_q != S_HALT)),
    .cnt   (cycle_cnt)
  );

  y86_sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .cnt   (instr_cnt)
  );

endmodule : y86_seq_sequencer

// File: tb/tb_y86_seq_sequencer.sv
// tb_y86_seq_sequencer: two sequencers driven by the same stimulus,
// dut0 (MEM_WAIT=0, CNT_W=32, RESET_PC=0x100) and dut2 (MEM_WAIT=2,
// CNT_W=4 so saturation is reached quickly, RESET_PC=0). A model that
// tracks each instruction as a position within its stage list is compared
// against both on every falling edge; literal checks pin the model.
module tb_y86_seq_sequencer;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, run, step, imem_err, instr_err, dmem_err;
  logic [3:0]  icode;
  logic [63:0] pc_in;
  logic        step_v;

`ifdef SEQ_STEP_EN
  assign step_v = step;
`else
  assign step_v = 1'b0;
`endif

  always #5 clk = ~clk;

  logic        fe0, de0, ee0, me0, we0, pe0, cc0, hl0;
  logic [63:0] pc0;
  logic [2:0]  st0;
  logic [31:0] cy0, in0;
  logic        fe2, de2, ee2, me2, we2, pe2, cc2, hl2;
  logic [63:0] pc2;
  logic [2:0]  st2;
  logic [3:0]  cy2, in2;

  y86_seq_sequencer #(.PC_W(64), .CNT_W(32), .MEM_WAIT(0), .RESET_PC(64'h100)) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .icode(icode), .imem_err(imem_err), .instr_err(instr_err), .dmem_err(dmem_err),
    .pc_in(pc_in), .fetch_en(fe0), .decode_en(de0), .exec_en(ee0), .mem_en(me0),
    .wb_en(we0), .pc_en(pe0), .cc_en(cc0), .pc(pc0), .stat(st0), .halted(hl0),
    .cycle_cnt(cy0), .instr_cnt(in0));

  y86_seq_sequencer #(.PC_W(64), .CNT_W(4), .MEM_WAIT(2), .RESET_PC(64'h0)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .icode(icode), .imem_err(imem_err), .instr_err(instr_err), .dmem_err(dmem_err),
    .pc_in(pc_in), .fetch_en(fe2), .decode_en(de2), .exec_en(ee2), .mem_en(me2),
    .wb_en(we2), .pc_en(pe2), .cc_en(cc2), .pc(pc2), .stat(st2), .halted(hl2),
    .cycle_cnt(cy2), .instr_cnt(in2));

  logic [5:0] en0, en2;
  assign en0 = {fe0, de0, ee0, me0, we0, pe0};
  assign en2 = {fe2, de2, ee2, me2, we2, pe2};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k is the cycle index inside the current instruction:
  // 0 fetch, 1 decode, 2 execute, 3..3+mw memory, 4+mw writeback, 5+mw pc update.
  typedef struct packed {
    logic        busy;
    logic        halted;
    logic        single;
    logic [7:0]  k;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [31:0] cyc;
    logic [31:0] ins;
  } model_t;

  function automatic model_t mreset(input logic [63:0] rpc);
    model_t n;
    n = '0;
    n.pc   = rpc;
    n.stat = STAT_AOK;
    return n;
  endfunction

  function automatic model_t mstep(input model_t m, input int mw, input logic [31:0] cmax,
                                   input logic run_v, input logic stp, input logic [3:0] ic,
                                   input logic ie, input logic xe, input logic dme,
                                   input logic [63:0] pcin);
    model_t n;
    int k;
    n = m;
    k = int'(m.k);
    if (m.halted) return n;
    if (!m.busy) begin
      if (run_v || stp) begin
        n.busy = 1'b1; n.k = 8'd0; n.single = !run_v;
      end
      return n;
    end
    if (n.cyc != cmax) n.cyc = n.cyc + 32'd1;
    if (k == 0 && (ie || xe || ic == 4'h0)) begin
      n.busy = 1'b0; n.halted = 1'b1;
      n.stat = ie ? STAT_ADR : (xe ? STAT_INS : STAT_HLT);
      if (!ie && !xe && n.ins != cmax) n.ins = n.ins + 32'd1;
      return n;
    end
    if (k == 3 + mw && dme) begin
      n.busy = 1'b0; n.halted = 1'b1; n.stat = STAT_ADR;
      return n;
    end
    if (k == 5 + mw) begin
      n.pc = pcin;
      if (n.ins != cmax) n.ins = n.ins + 32'd1;
      n.k = 8'd0;
      n.busy = run_v && !m.single;
      n.single = 1'b0;
      return n;
    end
    n.k = 8'(k + 1);
    return n;
  endfunction

  function automatic logic [5:0] exp_en(input model_t m, input int mw);
    int k;
    k = int'(m.k);
    if (!m.busy || m.halted) return 6'b000000;
    if (k == 0) return 6'b100000;
    if (k == 1) return 6'b010000;
    if (k == 2) return 6'b001000;
    if (k <= 3 + mw) return 6'b000100;
    if (k == 4 + mw) return 6'b000010;
    return 6'b000001;
  endfunction

  model_t m0, m2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= mreset(64'h100);
      m2 <= mreset(64'h0);
    end else begin
      m0 <= mstep(m0, 0, 32'hFFFF_FFFF, run, step_v, icode, imem_err, instr_err, dmem_err, pc_in);
      m2 <= mstep(m2, 2, 32'h0000_000F, run, step_v, icode, imem_err, instr_err, dmem_err, pc_in);
    end
  end

  task automatic compare(input string t, input model_t m, input int mw, input logic [5:0] en,
                         input logic cc, input logic [63:0] pcv, input logic [2:0] st,
                         input logic hl, input logic [31:0] cy, input logic [31:0] ins);
    logic [5:0] e;
    e = exp_en(m, mw);
    check({t, " enables"}, 64'(en), 64'(e));
    check({t, " cc_en"}, 64'(cc), 64'(e[3] && icode == 4'h6));
    check({t, " pc"}, pcv, m.pc);
    check({t, " stat"}, 64'(st), 64'(m.stat));
    check({t, " halted"}, 64'(hl), 64'(m.halted));
    check({t, " cycle_cnt"}, 64'(cy), 64'(m.cyc));
    check({t, " instr_cnt"}, 64'(ins), 64'(m.ins));
  endtask

  always @(negedge clk) begin
    compare("dut0", m0, 0, en0, cc0, pc0, st0, hl0, cy0, in0);
    compare("dut2", m2, 2, en2, cc2, pc2, st2, hl2, 32'(cy2), 32'(in2));
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
  endtask

  // Bounded wait on a dut0 stage enable; an expired bound is a failure.
  task automatic wait_en0(input int bitpos, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (en0[bitpos]) begin
        seen = 1'b1;
        break;
      end
      cycles(1);
    end
    check({"wait ", name}, 64'(seen), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; icode = 4'h6; pc_in = 64'h2;
    imem_err = 1'b0; instr_err = 1'b0; dmem_err = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    #1;
    check("reset pc0", pc0, 64'h100);
    check("reset stat0", 64'(st0), 64'd1);
    check("reset en0", 64'(en0), 64'd0);
    check("reset cyc0", 64'(cy0), 64'd0);

    // One OPq instruction, run pulsed for a single cycle.
    run = 1'b1;
    cycles(1);
    run = 1'b0;
    cycles(12);
    check("opq pc0", pc0, 64'h2);
    check("opq instr0", 64'(in0), 64'd1);
    check("opq cyc0", 64'(cy0), 64'd6);
    check("opq cyc2", 64'(cy2), 64'd8);
    check("opq idle0", 64'(en0), 64'd0);

    // Back-to-back non-OPq instructions; dut2's 4-bit cycle count saturates.
    icode = 4'h5; pc_in = 64'h40; run = 1'b1;
    cycles(20);
    run = 1'b0;
    cycles(12);
    check("run pc0", pc0, 64'h40);
    check("sat cyc2", 64'(cy2), 64'hF);

    // Reset while in MEMORY.
    icode = 4'h6; run = 1'b1;
    wait_en0(2, "mem_en0");
    rst_n = 1'b0;
    #1;
    check("midmem en0", 64'(en0), 64'd0);
    check("midmem en2", 64'(en2), 64'd0);
    check("midmem pc0", pc0, 64'h100);
    check("midmem instr0", 64'(in0), 64'd0);
    check("midmem cyc0", 64'(cy0), 64'd0);
    run = 1'b0;
    cycles(1);
    rst_n = 1'b1;

    // Data-address error held through the instruction.
    dmem_err = 1'b1; run = 1'b1;
    cycles(20);
    check("dmem stat0", 64'(st0), 64'd3);
    check("dmem halted0", 64'(hl0), 64'd1);
    check("dmem instr0", 64'(in0), 64'd0);
    check("dmem pc0", pc0, 64'h100);
    check("dmem stat2", 64'(st2), 64'd3);
    dmem_err = 1'b0; run = 1'b0;
    do_reset();

    // dmem_err only during the first MEMORY cycle: final for dut0, early for dut2.
    run = 1'b1;
    cycles(1);
    run = 1'b0;
    wait_en0(2, "mem_en0 pulse");
    dmem_err = 1'b1;
    cycles(1);
    dmem_err = 1'b0;
    cycles(10);
    check("pulse stat0", 64'(st0), 64'd3);
    check("pulse stat2", 64'(st2), 64'd1);
    check("pulse instr2", 64'(in2), 64'd1);
    do_reset();

    // HALT instruction.
    icode = 4'h0; run = 1'b1;
    cycles(10);
    check("hlt stat0", 64'(st0), 64'd2);
    check("hlt halted0", 64'(hl0), 64'd1);
    check("hlt instr0", 64'(in0), 64'd1);
    check("hlt pc0", pc0, 64'h100);
    check("hlt cyc0", 64'(cy0), 64'd1);
    run = 1'b0;
    do_reset();

    // Both fetch errors: ADR wins; then instruction error alone.
    icode = 4'h6; imem_err = 1'b1; instr_err = 1'b1; run = 1'b1;
    cycles(4);
    check("adr wins stat0", 64'(st0), 64'd3);
    run = 1'b0;
    do_reset();
    imem_err = 1'b0; run = 1'b1;
    cycles(4);
    check("ins stat0", 64'(st0), 64'd4);
    run = 1'b0; instr_err = 1'b0;
    do_reset();

`ifdef SEQ_STEP_EN
    // Single step: one instruction, then back to IDLE.
    pc_in = 64'h80; step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(12);
    check("step instr0", 64'(in0), 64'd1);
    check("step pc0", pc0, 64'h80);
    check("step idle0", 64'(en0), 64'd0);
    check("step cyc0", 64'(cy0), 64'd6);
    do_reset();
`endif

    // run dropped during EXECUTE: the instruction still completes.
    pc_in = 64'hC0; run = 1'b1;
    wait_en0(3, "exec_en0");
    run = 1'b0;
    cycles(12);
    check("drop instr0", 64'(in0), 64'd1);
    check("drop pc0", pc0, 64'hC0);
    check("drop idle0", 64'(en0), 64'd0);

    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_y86_seq_sequencer

// File: doc/y86_seq_sequencer.md
# y86_seq_sequencer

Multi-cycle stage controller for the Y86-64 SEQ datapath. It drives fetch, decode, execute, memory, write-back and PC-update one stage per clock through per-stage enables, and owns the architectural PC and the processor status register. It also keeps saturating cycle and retired-instruction counters. It sits above the existing stage modules and replaces free-running combinational PC feedback with a clocked, stallable sequence.

## Interface
- PC_W, 64, width of PC
- CNT_W, 32, width of cycle/instruction counters
- MEM_WAIT, 0, extra wait cycles in MEMORY stage (0..15)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; permits starting new instructions
- icode  in  4  instruction code from fetch stage
- imem_err  in  1  instruction-address error from fetch
- instr_err  in  1  invalid-instruction flag from fetch
- dmem_err  in  1  data-address error from memory stage
- pc_in  in  PC_W  next PC from PC-update logic
- fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  out  1 each  stage enables, one-hot or all zero
- cc_en  out  1  condition-code latch enable
- pc  out  PC_W  architectural PC
- stat  out  3  AOK=1, HLT=2, ADR=3, INS=4
- halted  out  1  high in HALT state
- cycle_cnt  out  CNT_W  active cycles
- instr_cnt  out  CNT_W  retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. The enables are decoded from the state register (Moore) and are zero in IDLE and HALT.
- IDLE -> FETCH when run=1.
- FETCH -> DECODE, with errors sampled at the edge that ends FETCH, in priority order:
  - imem_err: stat=ADR, go to HALT.
  - else instr_err: stat=INS, go to HALT.
  - else icode==0: stat=HLT, instr_cnt++, go to HALT.
- DECODE -> EXECUTE.
- EXECUTE -> MEMORY. cc_en=1 in EXECUTE only when icode==6 (OPq); icode is held stable by fetch for the whole instruction.
- MEMORY lasts 1+MEM_WAIT cycles, counted by an internal wait counter that reloads on entry. dmem_err is sampled only on the last MEMORY cycle; if set, stat=ADR and go to HALT (no WRITEBACK, no PC update, no retire). Otherwise go to WRITEBACK.
- WRITEBACK -> PCUPD.
- PCUPD: pc <= pc_in, instr_cnt++. Go to FETCH if run=1, else IDLE.
- Dropping run mid-instruction does not abort; the instruction completes through PCUPD.
- HALT is exited only by reset; pc, stat and the counters are frozen.
- cycle_cnt increments every cycle the state is not IDLE/HALT. Both counters saturate at all-ones and never wrap.

## Timing
- Reset (async assert, sync-safe deassert at clk): state=IDLE, pc=RESET_PC, stat=AOK, halted=0, all enables 0, cc_en=0, both counters 0, wait counter 0.
- Reset while any stage enable is active: all enables drop immediately on assertion; no partial PC update survives.
- Normal instruction: 6+MEM_WAIT cycles from entering FETCH to the pc update. The new pc is visible the cycle after the PCUPD edge, coincident with the next FETCH.
- Error flags only need to be valid at the edge ending their stage; values at other times are ignored.

## Configuration
- SEQ_STEP_EN defined: adds input port step (1 bit). In IDLE, step=1 with run=0 launches exactly one instruction, which returns to IDLE after PCUPD regardless of step. step is ignored outside IDLE; run has priority when both are high.
- SEQ_STEP_EN undefined: no step port; only run starts instructions.

## Structure
- Shared package y86_pkg holds the stat encodings (AOK/HLT/ADR/INS), the icode constants (HALT=0, OPQ=6) and the sequencer state enum, so that fetch/PC-update and the benches share them.
- One sub-module: y86_sat_counter (parameter W; ports clk, rst_n, inc; output cnt), instantiated twice for cycle_cnt and instr_cnt.

## Test plan
- Reset with rst_n=0 mid-MEMORY -> pc=RESET_PC, stat=1, all enables 0, both counters 0, state IDLE.
- MEM_WAIT=0, run=1, icode=6, pc_in=2 -> enables go fetch..pc over 6 consecutive cycles, cc_en high only during exec_en, then pc=2, instr_cnt=1, cycle_cnt=6.
- MEM_WAIT=2, icode=5 -> mem_en high for 3 cycles, instruction takes 8 cycles, cc_en stays 0.
- icode=0 at the end of FETCH -> stat=2, halted=1, instr_cnt=1, pc unchanged, no enables afterwards despite run=1.
- dmem_err=1 on the last MEMORY cycle -> stat=3, wb_en and pc_en never assert, instr_cnt unchanged. Separately, imem_err and instr_err set together -> stat=3 (ADR wins).
- run dropped during EXECUTE -> completes through PCUPD then IDLE. With SEQ_STEP_EN, a one-cycle step pulse -> exactly one instruction retires (instr_cnt +1) and the sequencer returns to IDLE.
